// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared state encoding and default window base for the data-memory controller
package dmem_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACCESS = 3'd2,
    S_RDATA  = 3'd3,
    S_RESP   = 3'd4
  } state_t;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;
endpackage

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-outstanding valid/ready data-bus slave driving a byte-enabled synchronous SRAM
//   clk, rst_n (async, active-low)
//   req_*  : request channel (valid/ready, addr, wdata, sel, we)
//   rsp_*  : response channel (valid/ready, rdata, err), held stable until accepted
//   ram_*  : SRAM port, active only in the ACCESS state; ram_rdata_i valid one cycle after a read
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          RAM_AW      = 12,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [3:0]        req_sel_i,
  input  logic              req_we_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              ram_cs_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_be_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);
  localparam logic [2:0] WLOAD = 3'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  state_t state_q, state_d;
  logic [2:0] cnt_q;
  logic [RAM_AW-1:0] addr_q;
  logic [31:0] wdata_q, rdata_q;
  logic [3:0] sel_q;
  logic we_q, err_q;
  logic in_win, accept, acc;
  // byte offset within a word is deliberately ignored
  logic unused_byte_off;
  assign unused_byte_off = ^req_addr_i[1:0];
  assign in_win = req_addr_i[31:RAM_AW+2] == BASE_ADDR[31:RAM_AW+2];
  assign accept = state_q == S_IDLE && req_valid_i;
  assign acc = state_q == S_ACCESS;
  // held low while reset is asserted so every output reads 0 during reset
  assign req_ready_o = state_q == S_IDLE && rst_n;
  assign rsp_valid_o = state_q == S_RESP;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o = err_q;
  assign ram_cs_o = acc;
  assign ram_we_o = acc & we_q;
  assign ram_be_o = acc ? (we_q ? sel_q : 4'hF) : 4'h0;
  assign ram_addr_o = acc ? addr_q : '0;
  assign ram_wdata_o = acc ? wdata_q : '0;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid_i) state_d = !in_win ? S_RESP : (WAIT_CYCLES == 0 ? S_ACCESS : S_WAIT);
      S_WAIT:   if (cnt_q == 3'd0) state_d = S_ACCESS;
      S_ACCESS: state_d = we_q ? S_RESP : S_RDATA;
      S_RDATA:  state_d = S_RESP;
      S_RESP:   if (rsp_ready_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= req_addr_i[RAM_AW+1:2];
        wdata_q <= req_wdata_i;
        sel_q <= req_sel_i;
        we_q <= req_we_i;
        err_q <= !in_win;
        rdata_q <= '0;
        cnt_q <= WLOAD;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (state_q == S_RDATA) rdata_q <= ram_rdata_i;
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed checks of dmem_ctrl with zero and three wait states
module tb_dmem_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic req_valid[2], req_ready[2], req_we[2], rsp_valid[2], rsp_ready[2], rsp_err[2], ram_cs[2], ram_we[2];
  logic [31:0] req_addr[2], req_wdata[2], rsp_rdata[2], ram_wdata[2];
  logic [3:0] req_sel[2], ram_be[2];
  logic [11:0] ram_addr[2];
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : gi
    logic [31:0] mem [16];
    logic [31:0] rd;
    dmem_ctrl #(.WAIT_CYCLES(g * 3)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid[g]), .req_ready_o(req_ready[g]), .req_addr_i(req_addr[g]),
      .req_wdata_i(req_wdata[g]), .req_sel_i(req_sel[g]), .req_we_i(req_we[g]),
      .rsp_valid_o(rsp_valid[g]), .rsp_ready_i(rsp_ready[g]), .rsp_rdata_o(rsp_rdata[g]), .rsp_err_o(rsp_err[g]),
      .ram_cs_o(ram_cs[g]), .ram_we_o(ram_we[g]), .ram_be_o(ram_be[g]), .ram_addr_o(ram_addr[g]),
      .ram_wdata_o(ram_wdata[g]), .ram_rdata_i(rd)
    );
    always @(posedge clk) begin
      if (ram_cs[g]) begin
        if (ram_we[g]) begin
          for (int b = 0; b < 4; b++)
            if (ram_be[g][b]) mem[ram_addr[g][3:0]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
        end else begin
          rd <= mem[ram_addr[g][3:0]];
        end
      end
    end
  end
  // presents a request at the current falling edge; returns at the falling edge of cycle T+1
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
    req_valid[i] = 1'b1;
    req_addr[i] = a;
    req_wdata[i] = d;
    req_sel[i] = s;
    req_we[i] = w;
    @(negedge clk);
    req_valid[i] = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0; req_sel[i] = '0; req_we[i] = 1'b0; rsp_ready[i] = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_ready[0], rsp_valid[0], rsp_err[0], ram_cs[0], ram_we[0], ram_be[0]} !== 9'd0 || rsp_rdata[0] !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: ready=%b valid=%b err=%b cs=%b we=%b be=%h rdata=%h, want all 0",
               req_ready[0], rsp_valid[0], rsp_err[0], ram_cs[0], ram_we[0], ram_be[0], rsp_rdata[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready[0] !== 1'b1 || req_ready[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b%b want 11", req_ready[0], req_ready[1]);
    end
  endtask
  task automatic test_write();
    issue(0, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1);
    n_cmp++;
    if ({ram_cs[0], ram_we[0], ram_be[0], ram_addr[0], ram_wdata[0], rsp_valid[0]} !== {1'b1, 1'b1, 4'hF, 12'd1, 32'hDEAD_BEEF, 1'b0}) begin
      n_bad++;
      $display("FAIL write_access: cs=%b we=%b be=%h addr=%h wdata=%h valid=%b want 1 1 f 001 deadbeef 0",
               ram_cs[0], ram_we[0], ram_be[0], ram_addr[0], ram_wdata[0], rsp_valid[0]);
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid[0], rsp_err[0], rsp_rdata[0], ram_cs[0]} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL write_resp: valid=%b err=%b rdata=%h cs=%b want 1 0 00000000 0", rsp_valid[0], rsp_err[0], rsp_rdata[0], ram_cs[0]);
    end
    @(negedge clk);
  endtask
  task automatic test_read();
    issue(0, 32'h1000_0004, 32'h0, 4'h0, 1'b0);
    n_cmp++;
    if ({ram_cs[0], ram_we[0], ram_be[0], ram_addr[0]} !== {1'b1, 1'b0, 4'hF, 12'd1}) begin
      n_bad++;
      $display("FAIL read_access: cs=%b we=%b be=%h addr=%h want 1 0 f 001", ram_cs[0], ram_we[0], ram_be[0], ram_addr[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid[0] !== 1'b0 || ram_cs[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL read_t2: valid=%b cs=%b want 0 0", rsp_valid[0], ram_cs[0]);
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid[0], rsp_err[0], rsp_rdata[0]} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL read_resp: valid=%b err=%b rdata=%h want 1 0 deadbeef", rsp_valid[0], rsp_err[0], rsp_rdata[0]);
    end
    @(negedge clk);
  endtask
  task automatic test_byte_write();
    issue(0, 32'h1000_0005, 32'h0000_AB00, 4'b0010, 1'b1);
    n_cmp++;
    if ({ram_cs[0], ram_we[0], ram_be[0], ram_addr[0]} !== {1'b1, 1'b1, 4'b0010, 12'd1}) begin
      n_bad++;
      $display("FAIL byte_write_access: cs=%b we=%b be=%b addr=%h want 1 1 0010 001", ram_cs[0], ram_we[0], ram_be[0], ram_addr[0]);
    end
    @(negedge clk);
    @(negedge clk);
    issue(0, 32'h1000_0004, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEAD_ABEF) begin
      n_bad++;
      $display("FAIL byte_write_readback: valid=%b rdata=%h want 1 deadabef", rsp_valid[0], rsp_rdata[0]);
    end
    @(negedge clk);
  endtask
  task automatic test_zero_sel();
    issue(0, 32'h1000_0004, 32'hFFFF_FFFF, 4'h0, 1'b1);
    n_cmp++;
    if ({ram_cs[0], ram_we[0], ram_be[0]} !== {1'b1, 1'b1, 4'h0}) begin
      n_bad++;
      $display("FAIL zero_sel_access: cs=%b we=%b be=%b want 1 1 0000", ram_cs[0], ram_we[0], ram_be[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_sel_resp: valid=%b err=%b want 1 0", rsp_valid[0], rsp_err[0]);
    end
    @(negedge clk);
  endtask
  task automatic test_error();
    issue(0, 32'h2000_0000, 32'h0, 4'hF, 1'b0);
    n_cmp++;
    if ({rsp_valid[0], rsp_err[0], rsp_rdata[0], ram_cs[0]} !== {1'b1, 1'b1, 32'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL error_resp: valid=%b err=%b rdata=%h cs=%b want 1 1 00000000 0", rsp_valid[0], rsp_err[0], rsp_rdata[0], ram_cs[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (req_ready[0] !== 1'b1 || ram_cs[0] !== 1'b0 || rsp_valid[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL error_done: ready=%b cs=%b valid=%b want 1 0 0", req_ready[0], ram_cs[0], rsp_valid[0]);
    end
  endtask
  task automatic test_backpressure();
    rsp_ready[0] = 1'b0;
    issue(0, 32'h1000_0004, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({rsp_valid[0], rsp_err[0], rsp_rdata[0], req_ready[0]} !== {1'b1, 1'b0, 32'hDEAD_ABEF, 1'b0}) begin
        n_bad++;
        $display("FAIL backpressure_hold[%0d]: valid=%b err=%b rdata=%h ready=%b want 1 0 deadabef 0",
                 k, rsp_valid[0], rsp_err[0], rsp_rdata[0], req_ready[0]);
      end
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL backpressure_release: valid=%b ready=%b want 0 1", rsp_valid[0], req_ready[0]);
    end
  endtask
  task automatic test_wait_states();
    logic [7:0] cs_seen, vld_seen;
    issue(1, 32'h1000_0008, 32'h1234_5678, 4'hF, 1'b1);
    for (int k = 1; k < 6; k++) @(negedge clk);
    issue(1, 32'h1000_0008, 32'h0, 4'h0, 1'b0);
    cs_seen = '0;
    vld_seen = '0;
    for (int k = 1; k <= 7; k++) begin
      cs_seen[k] = ram_cs[1];
      vld_seen[k] = rsp_valid[1];
      if (k == 6) begin
        n_cmp++;
        if (rsp_rdata[1] !== 32'h1234_5678) begin
          n_bad++;
          $display("FAIL wait_rdata: got %h want 12345678", rsp_rdata[1]);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (cs_seen !== 8'b0001_0000 || vld_seen !== 8'b0100_0000) begin
      n_bad++;
      $display("FAIL wait_timing: cs cycles=%b valid cycles=%b want 00010000 01000000", cs_seen, vld_seen);
    end
  endtask
  task automatic test_reset_mid();
    logic seen;
    issue(1, 32'h1000_0008, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready[1], rsp_valid[1], rsp_err[1], ram_cs[1], ram_we[1], ram_be[1]} !== 9'd0 || rsp_rdata[1] !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mid_drop: ready=%b valid=%b err=%b cs=%b we=%b be=%h rdata=%h want all 0",
               req_ready[1], rsp_valid[1], rsp_err[1], ram_cs[1], ram_we[1], ram_be[1], rsp_rdata[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_ready: got %b want 1", req_ready[1]);
    end
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen |= rsp_valid[1] | ram_cs[1];
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_no_resp: activity=%b want 0", seen);
    end
  endtask
  initial begin
    test_reset();
    test_write();
    test_read();
    test_byte_write();
    test_zero_sel();
    test_error();
    test_backpressure();
    test_wait_states();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
